// File: rtl/iob2axi_burst_split_if.sv
// iob2axi_burst_split_if: host request/status and burst-engine handshake for the burst splitter
interface iob2axi_burst_split_if #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int TOTAL_LEN_W = 16
) ();
  logic                   start;
  logic                   direction;
  logic [AXI_ADDR_W-1:0]  addr;
  logic [TOTAL_LEN_W-1:0] length;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic                   b_run;
  logic                   b_direction;
  logic [AXI_ADDR_W-1:0]  b_addr;
  logic [AXI_LEN_W-1:0]   b_len;
  logic                   b_ready;
  logic                   b_error;
  modport slave (
    input  start, direction, addr, length, b_ready, b_error,
    output busy, done, error, b_run, b_direction, b_addr, b_len
  );
  modport master (
    output start, direction, addr, length, b_ready, b_error,
    input  busy, done, error, b_run, b_direction, b_addr, b_len
  );
endinterface

// File: rtl/iob2axi_burst_split.sv
// iob2axi_burst_split: splits a beat-counted transfer into AXI bursts that never cross 4 KB
module iob2axi_burst_split #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_DATA_W  = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int TOTAL_LEN_W = 16
) (
  input logic clk,
  input logic rst,
  iob2axi_burst_split_if.slave bus
);
  localparam int BYTES = AXI_DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int BLW   = AXI_LEN_W + 1;
  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} state_t;
  state_t                 state, state_n;
  logic [AXI_ADDR_W-1:0]  cur_addr, issue_addr;
  logic [TOTAL_LEN_W-1:0] remaining;
  logic [AXI_LEN_W-1:0]   issue_len;
  logic [BLW-1:0]         burst;
  logic                   wait_first, error, issue_dir;
  logic                   bad_start, complete, last;
  logic [12:0]            beats_4k;
  logic [31:0]            burst_c;
  assign bad_start = bus.length == '0 || bus.addr[OFF_W-1:0] != '0;
  assign beats_4k  = (13'd4096 - {1'b0, cur_addr[11:0]}) >> OFF_W;
  // the engine may still show b_ready in the first WAIT cycle, so completion waits one cycle
  assign complete  = state == WAIT && !wait_first && bus.b_ready;
  assign last      = 32'(remaining) == 32'(burst);
  always_comb begin
    burst_c = 32'(remaining);
    burst_c = burst_c > (32'd1 << AXI_LEN_W) ? (32'd1 << AXI_LEN_W) : burst_c;
    burst_c = burst_c > 32'(beats_4k) ? 32'(beats_4k) : burst_c;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? (bad_start ? DONE : CALC) : IDLE;
      CALC:    state_n = ISSUE;
      ISSUE:   state_n = bus.b_ready ? WAIT : ISSUE;
      WAIT:    state_n = complete ? (bus.b_error || last ? DONE : CALC) : WAIT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      burst      <= '0;
      wait_first <= 1'b0;
      error      <= 1'b0;
      issue_addr <= '0;
      issue_len  <= '0;
      issue_dir  <= 1'b0;
    end else begin
      state      <= state_n;
      wait_first <= state == ISSUE;
      if (state == IDLE && bus.start) begin
        if (bad_start) begin
          error <= 1'b1;
        end else begin
          cur_addr  <= bus.addr;
          remaining <= bus.length;
          issue_dir <= bus.direction;
          error     <= 1'b0;
        end
      end
      if (state == CALC) begin
        burst      <= BLW'(burst_c);
        issue_addr <= cur_addr;
        issue_len  <= AXI_LEN_W'(burst_c - 32'd1);
      end
      if (complete) begin
        if (bus.b_error) begin
          error <= 1'b1;
        end else begin
          cur_addr  <= cur_addr + AXI_ADDR_W'(32'(burst) * BYTES);
          remaining <= remaining - TOTAL_LEN_W'(burst);
        end
      end
    end
  end
  assign bus.busy        = state != IDLE;
  assign bus.done        = state == DONE;
  assign bus.error       = error;
  assign bus.b_run       = state == ISSUE && bus.b_ready;
  assign bus.b_direction = issue_dir;
  assign bus.b_addr      = issue_addr;
  assign bus.b_len       = issue_len;
endmodule

// File: doc/iob2axi_burst_split.md
IOB2AXI_BURST_SPLIT -- requirements
Module: iob2axi_burst_split

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter AXI_DATA_W, default 32: AXI data width, a power of two, 32..1024; beat size BYTES = AXI_DATA_W/8.
REQ-003 SHALL have parameter AXI_LEN_W, default 8: AXI burst length field width (maximum burst 2^AXI_LEN_W beats).
REQ-004 SHALL have parameter TOTAL_LEN_W, default 16: transfer length width, in beats.
REQ-005 SHALL use these ports:
  - clk  in  1  clock, rising edge.
  - rst  in  1  reset, asynchronous, active-high.
  - start  in  1  request a transfer; sampled only in IDLE.
  - direction  in  1  0 = read, 1 = write.
  - addr  in  AXI_ADDR_W  start byte address.
  - length  in  TOTAL_LEN_W  transfer size in beats.
  - busy  out  1  high whenever state != IDLE.
  - done  out  1  one-cycle end-of-transfer pulse.
  - error  out  1  sticky transfer error.
  - b_run  out  1  one-cycle burst launch pulse to the rd/wr engine.
  - b_direction  out  1  latched direction.
  - b_addr  out  AXI_ADDR_W  burst start byte address.
  - b_len  out  AXI_LEN_W  burst beats minus 1 (AXI encoding).
  - b_ready  in  1  engine idle/finished.
  - b_error  in  1  engine error, valid while b_ready = 1.

Function
REQ-006 SHALL implement FSM states IDLE, CALC, ISSUE, WAIT, DONE.
REQ-007 IDLE, start = 1 with length = 0 or addr[log2(BYTES)-1:0] != 0: SHALL set error = 1 and go to DONE; no b_run is issued.
REQ-008 IDLE, start = 1 otherwise: SHALL latch addr, length and direction into cur_addr/remaining, clear error, and go to CALC.
REQ-009 In CALC, beats_4k SHALL be (4096 - cur_addr[11:0]) / BYTES, computed at 13-bit width.
REQ-010 In CALC, burst SHALL be min(remaining, 2^AXI_LEN_W, beats_4k).
REQ-011 In CALC, the block SHALL register b_addr = cur_addr and b_len = burst - 1, then go to ISSUE.
REQ-012 In ISSUE with b_ready = 1: SHALL assert b_run for exactly one cycle and go to WAIT; otherwise SHALL hold in ISSUE.
REQ-013 WAIT SHALL ignore b_ready in its first cycle; the engine drops b_ready no later than one cycle after b_run.
REQ-014 From the second WAIT cycle, b_ready = 1 SHALL mark the burst complete.
REQ-015 On burst completion with b_error = 1: SHALL set error and go to DONE, abandoning the remaining bursts.
REQ-016 On burst completion with b_error = 0: SHALL update cur_addr += burst*BYTES (modulo 2^AXI_ADDR_W) and remaining -= burst.
REQ-017 After the update of REQ-016: go to DONE if remaining = 0, else to CALC.
REQ-018 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-019 error SHALL remain set until the next accepted start.
REQ-020 start asserted outside IDLE SHALL be ignored; there is no queuing.
REQ-021 b_addr, b_len and b_direction SHALL be stable from ISSUE entry until the next CALC.
REQ-022 Latency: with b_ready = 1, the first b_run SHALL occur 2 cycles after start is sampled.
REQ-023 Latency: the next b_run SHALL occur 2 cycles after burst completion.
REQ-024 No burst SHALL cross a 4 KB boundary, and no burst SHALL exceed 2^AXI_LEN_W beats.

Reset
REQ-025 On rst the block SHALL enter IDLE, with busy, done, error, b_run, b_direction, b_addr, b_len and all internal counters at 0.
REQ-026 Reset mid-transfer, in any state, SHALL abort immediately with no further b_run and no done pulse.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Verification (AXI_DATA_W = 32, BYTES = 4, engine model answering b_ready 3 cycles after b_run)
REQ-028 addr 0x0000, length 16 -> one burst (b_addr 0x0000, b_len 15); done pulse; error = 0.
REQ-029 addr 0x0FF0, length 8 -> two bursts: (0x0FF0, b_len 3) then (0x1000, b_len 3); done; error = 0.
REQ-030 addr 0x2000, length 600 -> three bursts: (0x2000, 255), (0x2400, 255), (0x2800, 87); done; error = 0.
REQ-031 length 0 or addr 0x0002 -> no b_run; done one cycle later; error = 1; busy low again after done.
REQ-032 addr 0x0000, length 768, b_error = 1 on the first completion -> exactly one b_run; error = 1; done pulse.
REQ-033 rst pulsed while in WAIT of the 2nd burst -> all outputs 0, no done pulse; a new start (0x0000, 4) then completes normally.
